// File: rtl/frame_strobe_driver_if.sv
// Word stream from the bitstream loader into a column frame writer.
// A word moves on every rising clock edge where s_valid && s_ready. While s_valid
// is high and s_ready is low, the master holds s_data steady. s_ready may depend
// only on the receiver's state, never on s_valid.
interface frame_strobe_driver_if #(
   parameter int DataWidth = 32
);
   logic                 s_valid;
   logic                 s_ready;
   logic [DataWidth-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/frame_strobe_driver.sv
// Column frame writer: takes a header and NumRows words, then pulses one FrameStrobe line.
// Define HEADER_PARITY_EN to require odd parity over header bits [31:15].
module frame_strobe_driver #(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 4,
   parameter int ColumnId        = 0,
   parameter int StrobeCycles    = 1
) (
   input  logic                                 UserCLK,
   input  logic                                 RST,
   frame_strobe_driver_if.slave                 loader,
   output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 busy,
   output logic                                 err,
   output logic [1:0]                           dbgState
);

   localparam int FrameW = FrameBitsPerRow * NumRows;
   localparam int CntW   = (NumRows > 1) ? $clog2(NumRows) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                     state;
   state_t                     stateNext;
   logic [7:0]                 frameIdx;
   logic                       suppress;
   logic [CntW-1:0]            wordCnt;
   logic [3:0]                 strobeCnt;
   logic [MaxFramesPerCol-1:0] strobeVec;

   logic xfer;
   logic hdrXfer;
   logic colMatch;
   logic idxBad;
   logic hdrAccept;
   logic parityErr;
   logic lastWord;
   logic strobeDone;

   assign loader.s_ready = (state == IDLE) || (state == LOAD);
   assign busy           = (state != IDLE);
   assign dbgState       = state;

   assign xfer       = loader.s_valid && loader.s_ready;
   assign hdrXfer    = xfer && (state == IDLE);
   assign colMatch   = (loader.s_data[31:24] == 8'(ColumnId));
   assign idxBad     = ({1'b0, loader.s_data[23:16]} >= 9'(MaxFramesPerCol));
   assign lastWord   = (wordCnt == CntW'(NumRows - 1));
   assign strobeDone = (strobeCnt == 4'(StrobeCycles - 1));

`ifdef HEADER_PARITY_EN
   // Parity gates acceptance before the column match; only our own column flags err.
   logic parityOk;
   assign parityOk  = ^loader.s_data[31:15];
   assign hdrAccept = hdrXfer && colMatch && parityOk;
   assign parityErr = hdrXfer && colMatch && !parityOk;
`else
   assign hdrAccept = hdrXfer && colMatch;
   assign parityErr = 1'b0;
`endif

   always_comb begin
      strobeVec = '0;
      for (int i = 0; i < MaxFramesPerCol; i++) begin
         if (frameIdx == 8'(i)) strobeVec[i] = 1'b1;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (hdrAccept) stateNext = LOAD;
         LOAD:    if (xfer && lastWord) stateNext = suppress ? HOLD : STROBE;
         STROBE:  if (strobeDone) stateNext = HOLD;
         HOLD:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         frameIdx  <= '0;
         suppress  <= 1'b0;
         wordCnt   <= '0;
         strobeCnt <= '0;
         FrameData <= '0;
         err       <= 1'b0;
      end else begin
         state <= stateNext;

         if (hdrAccept) begin
            frameIdx <= loader.s_data[23:16];
            suppress <= idxBad;
         end

         if ((hdrAccept && idxBad) || parityErr) err <= 1'b1;

         if (state == IDLE) wordCnt <= '0;
         else if (state == LOAD && xfer) wordCnt <= wordCnt + 1'b1;

         // First word ends up in the top slice once all NumRows words are in.
         if (state == LOAD && xfer)
            FrameData <= {FrameData[FrameW-FrameBitsPerRow-1:0], loader.s_data[FrameBitsPerRow-1:0]};

         if (state == STROBE) strobeCnt <= strobeCnt + 1'b1;
         else strobeCnt <= '0;
      end
   end

   // Strobe register follows the next state so it lines up exactly with STROBE.
   always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) FrameStrobe <= '0;
      else FrameStrobe <= (stateNext == STROBE) ? strobeVec : '0;
   end

endmodule
